// File: rtl/pe_bitserial_accum.sv
// -----------------------------------------------------------------------------
// pe_bitserial_accum
//
// Shift-and-accumulate back end for the CIM processing element. Each accepted
// slice carries LANE_NUM partial-sum lanes (lane k weighted by 2^k) plus two
// compensation lanes (comp0 weighted 1, comp1 weighted 2). Slices arrive MSB
// first, and the accumulator doubles before each later slice is added. One
// signed result per job is returned over a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             job start pulse (accepted only in IDLE)
//   mode[2:0]         000 8b (8 slices), 001 4b (4), 010 1b (1),
//                     100 FP16x1b (1 slice, compensation diverted to fp_q_sum)
//   signed_in         MSB slice carries negative weight (multi-slice modes)
//   abort             synchronous abort, highest priority
//   psum_valid        sum/compensation_sum carry one slice this cycle
//   sum               LANE_NUM lanes, lane k at [k*W +: W]
//   compensation_sum  comp0 in the low half, comp1 in the high half
//   busy              FSM is not IDLE
//   cfg_err           one-cycle pulse after a start with a reserved mode
//   out_valid/ready   result handshake (out_valid == state DONE)
//   acc_out           signed job result
//   fp_q_sum          last captured compensation_sum for mode 100, else 0
// -----------------------------------------------------------------------------
module pe_bitserial_accum #(
    parameter int LANE_NUM                = 10,
    parameter int ADDER_TREE_OUT_BITWIDTH = 9,
    parameter int MAX_SLICES              = 8,
    parameter int ACC_W                   = 28
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [2:0]                                  mode,
    input  logic                                        signed_in,
    input  logic                                        abort,
    input  logic                                        psum_valid,
    input  logic [LANE_NUM*ADDER_TREE_OUT_BITWIDTH-1:0] sum,
    input  logic [2*ADDER_TREE_OUT_BITWIDTH-1:0]        compensation_sum,
    output logic                                        busy,
    output logic                                        cfg_err,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ACC_W-1:0]                            acc_out,
    output logic [2*ADDER_TREE_OUT_BITWIDTH-1:0]        fp_q_sum
);

    localparam int W     = ADDER_TREE_OUT_BITWIDTH;
    localparam int CW    = 2 * W;
    localparam int CNT_W = $clog2(MAX_SLICES + 1);

    localparam logic [2:0] MODE_8B = 3'b000;
    localparam logic [2:0] MODE_4B = 3'b001;
    localparam logic [2:0] MODE_1B = 3'b010;
    localparam logic [2:0] MODE_FP = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         mode_q;
    logic               signed_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CW-1:0]      fp_q;
    logic               cfg_err_q;

    logic               mode_ok;
    logic               start_ok;
    logic               slice_fire;
    logic [CNT_W-1:0]   n_slices;
    logic               last_slice;
    logic [ACC_W-1:0]   comb;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign mode_ok = (mode == MODE_8B) || (mode == MODE_4B) ||
                     (mode == MODE_1B) || (mode == MODE_FP);

    // abort dominates both a fresh start and an incoming slice.
    assign start_ok   = (state_q == S_IDLE)  && start && mode_ok && !abort;
    assign slice_fire = (state_q == S_ACCUM) && psum_valid && !abort;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        n_slices = CNT_W'(1);
        case (mode_q)
            MODE_8B: n_slices = CNT_W'(8);
            MODE_4B: n_slices = CNT_W'(4);
            default: n_slices = CNT_W'(1);
        endcase
    end

    assign last_slice = (cnt_q == n_slices - CNT_W'(1));

    // Weighted sum of one slice; all terms unsigned and zero-extended.
    // In FP mode the compensation lanes bypass the accumulator entirely.
    always_comb begin
        comb = '0;
        for (int k = 0; k < LANE_NUM; k++) begin
            comb = comb + (ACC_W'(sum[k*W +: W]) << k);
        end
        if (mode_q != MODE_FP) begin
            comb = comb + ACC_W'(compensation_sum[W-1:0])
                        + (ACC_W'(compensation_sum[CW-1:W]) << 1);
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok)                state_d = S_ACCUM;
            S_ACCUM: if (slice_fire && last_slice) state_d = S_DONE;
            S_DONE:  if (out_ready)               state_d = S_IDLE;
            default:                              state_d = S_IDLE;
        endcase
        if (abort) state_d = S_IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_8B;
            signed_q  <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            fp_q      <= '0;
            cfg_err_q <= 1'b0;
        end else if (abort) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            fp_q      <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == S_IDLE) && start && !mode_ok;

            if (start_ok) begin
                mode_q   <= mode;
                signed_q <= signed_in;
                cnt_q    <= '0;
                fp_q     <= '0;
            end

            if (slice_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
                // The MSB slice seeds the accumulator; a single-slice job is
                // always unsigned, so negation needs at least two slices.
                if (cnt_q == '0) begin
                    acc_q <= (signed_q && (n_slices > CNT_W'(1))) ? -comb : comb;
                end else begin
                    acc_q <= (acc_q << 1) + comb;
                end
                if (mode_q == MODE_FP) fp_q <= compensation_sum;
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign acc_out   = acc_q;
    assign fp_q_sum  = fp_q;

endmodule
